// File: rtl/power_accum_pkg.sv
// rtl/power_accum_pkg.sv - shared types, helpers and parameter checks for power_accum
// Contents:
//   state_t       frame alignment state (WAIT_SOF / ACCUM)
//   clog2()       ceiling log2 for elaboration-time sizing
//   params_ok()   legality of the BITWIDTH/FFT_POINT/ACC_NUM/ACC_WIDTH set
package power_accum_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } state_t;

  localparam int POWER_WIDTH = 16;
  localparam int MAX_ACC_NUM = 256;
  localparam int MIN_FFT_POINT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The accumulator must hold ACC_NUM full-scale 16-bit samples without wrap,
  // and a bin must not be revisited while it is still inside the 2-deep pipe.
  function automatic bit params_ok(input int bitwidth, input int fft_point,
                                   input int acc_num, input int acc_width);
    return (acc_num >= 1) && (acc_num <= MAX_ACC_NUM) &&
           (acc_width >= POWER_WIDTH + clog2(acc_num)) &&
           (fft_point >= MIN_FFT_POINT) && (fft_point <= (1 << (bitwidth + 2)));
  endfunction

endpackage

// File: rtl/power_accum_if.sv
// rtl/power_accum_if.sv - sample stream in / integrated stream out bundle
// Signals:
//   en_sync_in, cnt_sync_in, power_in           power samples, one bin per valid cycle
//   en_sync_out, cnt_sync_out, acc_out          integrated power per bin
//   frame_done, sync_err                        last-bin pulse, sticky sequence error
// Modports: master drives samples (source side), slave is the accumulator.
interface power_accum_if #(
  parameter int BITWIDTH  = 7,
  parameter int ACC_WIDTH = 24
);
  logic                  en_sync_in;
  logic [BITWIDTH+1:0]   cnt_sync_in;
  logic [15:0]           power_in;
  logic                  en_sync_out;
  logic [BITWIDTH+1:0]   cnt_sync_out;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  frame_done;
  logic                  sync_err;

  modport master (
    output en_sync_in, cnt_sync_in, power_in,
    input  en_sync_out, cnt_sync_out, acc_out, frame_done, sync_err
  );

  modport slave (
    input  en_sync_in, cnt_sync_in, power_in,
    output en_sync_out, cnt_sync_out, acc_out, frame_done, sync_err
  );
endinterface

// File: rtl/power_accum_accum_ram.sv
// rtl/power_accum_accum_ram.sv - per-bin accumulator storage, simple dual port
// Ports:
//   clk                 clock
//   wr_en/addr/data     write port
//   rd_en/addr          read request, data registered into rd_data next cycle
//   rd_data             read data, held while rd_en is low
module accum_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are never cleared: the first spectrum of each frame overwrites.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/power_accum.sv
// rtl/power_accum.sv - integrates ACC_NUM power spectra per bin
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   power_accum_if.slave: samples in, integrated bins out (2 valid-advance latency)
module power_accum
  import power_accum_pkg::*;
#(
  parameter int BITWIDTH  = 7,
  parameter int FFT_POINT = 512,
  parameter int ACC_NUM   = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  power_accum_if.slave bus
);
  localparam int BW = BITWIDTH + 2;
  localparam int SW = (ACC_NUM > 1) ? clog2(ACC_NUM) : 1;
  localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_POINT - 1);
  localparam logic [SW-1:0] LAST_SPEC = SW'(ACC_NUM - 1);

  if (!params_ok(BITWIDTH, FFT_POINT, ACC_NUM, ACC_WIDTH)) begin : g_param_check
    $fatal(1, "power_accum: illegal parameter set");
  end

  state_t                state;
  logic [SW-1:0]         spec_cnt;
  logic [BW-1:0]         exp_bin;

  // Stage 1: sample accepted last advance, waiting for its RAM read data.
  logic                  s1_valid;
  logic                  s1_first;
  logic                  s1_last;
  logic [BW-1:0]         s1_bin;
  logic [15:0]           s1_power;

  logic                  en_out_q;
  logic [BW-1:0]         cnt_out_q;
  logic [ACC_WIDTH-1:0]  acc_out_q;
  logic                  frame_done_q;
  logic                  sync_err_q;

  logic [ACC_WIDTH-1:0]  rd_data;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  match;
  logic                  take;
  logic [SW-1:0]         cur_spec;

  always_comb begin
    match    = (state == ACCUM) && (bus.cnt_sync_in == exp_bin);
    // A bin 0 always (re)starts a frame, even as a mismatch.
    take     = match || (bus.cnt_sync_in == '0);
    cur_spec = match ? spec_cnt : '0;
    sum      = (s1_first ? '0 : rd_data) + ACC_WIDTH'(s1_power);
  end

  // Everything advances only on valid input so gaps stretch the pipe evenly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_SOF;
      spec_cnt     <= '0;
      exp_bin      <= '0;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_bin       <= '0;
      s1_power     <= '0;
      en_out_q     <= 1'b0;
      cnt_out_q    <= '0;
      acc_out_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      en_out_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.en_sync_in) begin
        if ((state == ACCUM) && !match) sync_err_q <= 1'b1;

        s1_valid <= take;
        s1_first <= (cur_spec == '0);
        s1_last  <= (cur_spec == LAST_SPEC);
        s1_bin   <= bus.cnt_sync_in;
        s1_power <= bus.power_in;

        if (take) begin
          state   <= ACCUM;
          exp_bin <= (bus.cnt_sync_in == LAST_BIN) ? '0 : bus.cnt_sync_in + 1'b1;
          if (bus.cnt_sync_in == LAST_BIN)
            spec_cnt <= (cur_spec == LAST_SPEC) ? '0 : cur_spec + 1'b1;
          else
            spec_cnt <= cur_spec;
        end else begin
          state    <= WAIT_SOF;
          spec_cnt <= '0;
        end

        if (s1_valid && s1_last) begin
          en_out_q     <= 1'b1;
          cnt_out_q    <= s1_bin;
          acc_out_q    <= sum;
          frame_done_q <= (s1_bin == LAST_BIN);
        end
      end
    end
  end

  accum_ram #(
    .ADDR_WIDTH (BW),
    .DATA_WIDTH (ACC_WIDTH)
  ) u_accum_ram (
    .clk     (clk),
    .wr_en   (bus.en_sync_in && s1_valid && !s1_last),
    .wr_addr (s1_bin),
    .wr_data (sum),
    .rd_en   (bus.en_sync_in),
    .rd_addr (bus.cnt_sync_in),
    .rd_data (rd_data)
  );

  assign bus.en_sync_out  = en_out_q;
  assign bus.cnt_sync_out = cnt_out_q;
  assign bus.acc_out      = acc_out_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.sync_err     = sync_err_q;
endmodule

// File: tb/tb_power_accum.sv
// tb/tb_power_accum.sv - bench for power_accum across four parameter sets
// u0: ACC_NUM 4, 512 bins   u1: ACC_NUM 16   u2: ACC_NUM 256, 64 bins   u3: ACC_NUM 1
module tb_power_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int FP [4] = '{512, 512, 64, 512};
  int AN [4] = '{4, 16, 256, 1};

  logic        en_i  [4];
  logic [8:0]  cnt_i [4];
  logic [15:0] pw_i  [4];
  logic        en_o  [4];
  logic [8:0]  cnt_o [4];
  logic [23:0] acc_o [4];
  logic        fd_o  [4];
  logic        se_o  [4];

  power_accum_if #(.BITWIDTH(7), .ACC_WIDTH(24)) if0 ();
  power_accum_if #(.BITWIDTH(7), .ACC_WIDTH(24)) if1 ();
  power_accum_if #(.BITWIDTH(4), .ACC_WIDTH(24)) if2 ();
  power_accum_if #(.BITWIDTH(7), .ACC_WIDTH(24)) if3 ();

  power_accum #(.BITWIDTH(7), .FFT_POINT(512), .ACC_NUM(4),   .ACC_WIDTH(24)) u0 (.clk(clk), .rst(rst), .bus(if0));
  power_accum #(.BITWIDTH(7), .FFT_POINT(512), .ACC_NUM(16),  .ACC_WIDTH(24)) u1 (.clk(clk), .rst(rst), .bus(if1));
  power_accum #(.BITWIDTH(4), .FFT_POINT(64),  .ACC_NUM(256), .ACC_WIDTH(24)) u2 (.clk(clk), .rst(rst), .bus(if2));
  power_accum #(.BITWIDTH(7), .FFT_POINT(512), .ACC_NUM(1),   .ACC_WIDTH(24)) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.en_sync_in = en_i[0]; assign if0.cnt_sync_in = cnt_i[0];      assign if0.power_in = pw_i[0];
  assign if1.en_sync_in = en_i[1]; assign if1.cnt_sync_in = cnt_i[1];      assign if1.power_in = pw_i[1];
  assign if2.en_sync_in = en_i[2]; assign if2.cnt_sync_in = cnt_i[2][5:0]; assign if2.power_in = pw_i[2];
  assign if3.en_sync_in = en_i[3]; assign if3.cnt_sync_in = cnt_i[3];      assign if3.power_in = pw_i[3];

  assign en_o[0] = if0.en_sync_out; assign cnt_o[0] = if0.cnt_sync_out;         assign acc_o[0] = if0.acc_out;
  assign en_o[1] = if1.en_sync_out; assign cnt_o[1] = if1.cnt_sync_out;         assign acc_o[1] = if1.acc_out;
  assign en_o[2] = if2.en_sync_out; assign cnt_o[2] = {3'b0, if2.cnt_sync_out}; assign acc_o[2] = if2.acc_out;
  assign en_o[3] = if3.en_sync_out; assign cnt_o[3] = if3.cnt_sync_out;         assign acc_o[3] = if3.acc_out;
  assign fd_o[0] = if0.frame_done;  assign se_o[0] = if0.sync_err;
  assign fd_o[1] = if1.frame_done;  assign se_o[1] = if1.sync_err;
  assign fd_o[2] = if2.frame_done;  assign se_o[2] = if2.sync_err;
  assign fd_o[3] = if3.frame_done;  assign se_o[3] = if3.sync_err;

  int n_checks = 0;
  int n_err = 0;
  int n_out [4] = '{0, 0, 0, 0};
  int n_fd  [4] = '{0, 0, 0, 0};
  bit cmp_on = 1'b0;
  bit gap_on = 1'b0;

  // Hand-computed per-instance expectations: 1 = constant, 2 = factor * bin.
  int     lit_kind [4] = '{1, 2, 1, 0};
  longint lit_val  [4] = '{400, 16, 64'hFF_FF00, 0};

  task automatic check(input int id, input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0d, expected %0d at %0t", id, name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-bin running sums over aligned spectra.
  bit     aligned [4];
  int     expb    [4];
  int     spec    [4];
  bit     serr    [4];
  longint acc     [4][512];
  bit     d1_v [4]; int d1_bin [4]; longint d1_sum [4];
  bit     o_v  [4]; int o_bin  [4]; longint o_sum  [4];
  bit     adv  [4];

  task automatic model_step(input int id, input int bin, input longint pw);
    bit ok;
    ok = aligned[id] && (bin == expb[id]);
    if (aligned[id] && !ok) serr[id] = 1'b1;
    if (!ok) begin
      spec[id]    = 0;
      aligned[id] = (bin == 0);
    end
    d1_v[id] = 1'b0;
    if (aligned[id]) begin
      acc[id][bin] = (spec[id] == 0) ? pw : acc[id][bin] + pw;
      d1_v[id]     = (spec[id] == AN[id] - 1);
      d1_bin[id]   = bin;
      d1_sum[id]   = acc[id][bin];
      expb[id]     = (bin + 1) % FP[id];
      if (bin == FP[id] - 1) spec[id] = (spec[id] + 1) % AN[id];
    end
  endtask

  // A sample emerges one cycle after the next valid advance following its own.
  always @(posedge clk) begin
    for (int id = 0; id < 4; id++) begin
      if (rst) begin
        aligned[id] = 1'b0; spec[id] = 0; expb[id] = 0; serr[id] = 1'b0;
        d1_v[id] = 1'b0; o_v[id] = 1'b0; adv[id] = 1'b0;
      end else begin
        adv[id] = en_i[id];
        if (en_i[id]) begin
          o_v[id] = d1_v[id]; o_bin[id] = d1_bin[id]; o_sum[id] = d1_sum[id];
          model_step(id, int'(cnt_i[id]), longint'(pw_i[id]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int id = 0; id < 4; id++) begin
        bit e_en;
        e_en = adv[id] && o_v[id];
        check(id, "en_sync_out", en_o[id], e_en);
        check(id, "frame_done", fd_o[id], e_en && (o_bin[id] == FP[id] - 1));
        check(id, "sync_err", se_o[id], serr[id]);
        if (en_o[id]) n_out[id]++;
        if (fd_o[id]) n_fd[id]++;
        if (e_en && en_o[id]) begin
          check(id, "cnt_sync_out", cnt_o[id], o_bin[id]);
          check(id, "acc_out", acc_o[id], o_sum[id]);
          if (lit_kind[id] == 1) check(id, "acc_out_literal", acc_o[id], lit_val[id]);
          if (lit_kind[id] == 2) check(id, "acc_out_literal", acc_o[id], lit_val[id] * cnt_o[id]);
        end
      end
    end
  end

  task automatic send(input int id, input int bin, input int pw);
    @(negedge clk);
    en_i[id]  = 1'b1;
    cnt_i[id] = 9'(bin);
    pw_i[id]  = 16'(pw);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int id = 0; id < 4; id++) en_i[id] = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // pw: >=0 constant, -1 power = bin index, -2 random power.
  task automatic spectra(input int id, input int lo, input int hi, input int n,
                         input int pw, input int skip);
    for (int s = 0; s < n; s++) begin
      for (int b = lo; b <= hi; b++) begin
        if (b != skip) begin
          int p;
          p = (pw == -1) ? b : (pw == -2) ? int'($urandom_range(65535)) : pw;
          if (gap_on) begin
            while ($urandom_range(1) == 1) begin
              @(negedge clk);
              en_i[id]  = 1'b0;
              cnt_i[id] = 9'($urandom_range(511));
            end
          end
          send(id, b, p);
        end
      end
    end
  endtask

  task automatic check_counts(input int id, input int outs, input int fds);
    check(id, "output_count", n_out[id], outs);
    check(id, "frame_done_count", n_fd[id], fds);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int id = 0; id < 4; id++) begin
      en_i[id] = 1'b0; cnt_i[id] = '0; pw_i[id] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 4; id++) begin
      check(id, "reset en_sync_out", en_o[id], 0);
      check(id, "reset cnt_sync_out", cnt_o[id], 0);
      check(id, "reset acc_out", acc_o[id], 0);
      check(id, "reset frame_done", fd_o[id], 0);
      check(id, "reset sync_err", se_o[id], 0);
    end
    @(negedge clk);
    rst    = 1'b0;
    cmp_on = 1'b1;

    // Start mid-spectrum: bins 200..511 are ignored, then two 4-spectrum frames of 100.
    spectra(0, 200, 511, 1, 100, -1);
    spectra(0, 0, 511, 8, 100, -1);
    spectra(0, 0, 511, 1, 100, -1);
    settle();
    check_counts(0, 1024, 2);
    check(0, "sync_err clean stream", se_o[0], 0);

    // Bin 37 missing in spectrum 2: frame dropped, realigned at next bin 0.
    spectra(0, 0, 511, 1, 100, -1);
    spectra(0, 0, 511, 1, 100, 37);
    settle();
    check(0, "sync_err after skip", se_o[0], 1);
    check_counts(0, 1024, 2);
    spectra(0, 0, 511, 4, 100, -1);

    // Reset in spectrum 2 of a frame carrying 999s; following frame must be 400.
    spectra(0, 0, 511, 2, 999, -1);
    settle();
    check_counts(0, 1536, 3);
    spectra(0, 0, 100, 1, 999, -1);
    @(negedge clk);
    rst = 1'b1;
    en_i[0] = 1'b0;
    settle();
    check(0, "mid reset en_sync_out", en_o[0], 0);
    check(0, "mid reset cnt_sync_out", cnt_o[0], 0);
    check(0, "mid reset acc_out", acc_o[0], 0);
    check(0, "mid reset frame_done", fd_o[0], 0);
    check(0, "mid reset sync_err", se_o[0], 0);
    @(negedge clk);
    rst = 1'b0;
    spectra(0, 0, 511, 4, 100, -1);
    send(0, 0, 0);
    idle(3);
    settle();
    check_counts(0, 2048, 4);
    check(0, "sync_err after reset", se_o[0], 0);

    // power = bin index over 16 spectra.
    spectra(1, 0, 511, 16, -1, -1);
    send(1, 0, 0);
    idle(3);
    settle();
    check_counts(1, 512, 1);

    // Full-scale power over 256 spectra reaches 0xFFFF00 without wrap.
    spectra(2, 0, 63, 256, 65535, -1);
    send(2, 0, 0);
    idle(3);
    settle();
    check_counts(2, 64, 1);

    // ACC_NUM 1 with random gaps and random power.
    gap_on = 1'b1;
    spectra(3, 0, 511, 2, -2, -1);
    send(3, 0, 0);
    gap_on = 1'b0;
    idle(3);
    settle();
    check_counts(3, 1024, 2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
